// File: rtl/stack_pkg.sv
// Shared definitions for the stack and its drain engine: drain FSM encoding,
// stack status bundle and output-buffer helpers.
package stack_pkg;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t IDLE  = 2'd0;
  localparam drain_state_t POP   = 2'd1;
  localparam drain_state_t FLUSH = 2'd2;
  localparam drain_state_t DONE  = 2'd3;

  typedef struct packed {
    logic empty;
    logic push;
  } stack_status_t;

  localparam int OBUF_DEPTH = 3;

  // Circular pointer over the three output-buffer slots.
  function automatic logic [1:0] obuf_ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stack_drain_obuf.sv
// Three-entry FIFO of {last, data} beats feeding the drain output stream.
module stack_drain_obuf
  import stack_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH:0]   wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH:0]   rd_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH:0] mem_q [OBUF_DEPTH];
  logic [1:0]     wr_ptr_q;
  logic [1:0]     rd_ptr_q;
  logic [1:0]     count_q;
  logic [1:0]     count_d;
  logic           rd_fire;
  logic           wr_ok;

  assign rd_fire = (count_q != 2'd0) && rd_ready_i;
  // A write into a full buffer is only accepted when a beat leaves the same cycle.
  assign wr_ok   = wr_en_i && ((count_q != 2'd3) || rd_fire);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_fire) begin
      count_d = count_q + 2'd1;
    end else if (!wr_ok && rd_fire) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= obuf_ptr_inc(wr_ptr_q);
      end
      if (rd_fire) begin
        rd_ptr_q <= obuf_ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign rd_valid_o = (count_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/stack_drain.sv
// Drain engine: pops a LIFO stack into a ready/valid stream, either a fixed
// number of entries or until empty, then reports how many were popped.
module stack_drain
  import stack_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] stk_data,
  input  logic             stk_empty,
  input  logic             stk_push,
  output logic             stk_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] done_count,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] cmd_cnt_q;
  logic [CNT_W-1:0] pop_cnt_q;
  logic             pend_valid_q;
  logic [WIDTH-1:0] pend_data_q;
  logic [CNT_W-1:0] done_count_q;
  logic             underflow_q;
  logic [1:0]       obuf_count;
  logic [2:0]       occupancy;
  logic             limit_ok;
  logic             pend_last;
  logic [WIDTH:0]   obuf_rd_data;
  stack_status_t    stk_st;

  assign stk_st    = '{empty: stk_empty, push: stk_push};
  assign occupancy = {1'b0, obuf_count} + {2'b00, pend_valid_q};
  assign limit_ok  = (cmd_cnt_q == '0) || (pop_cnt_q < cmd_cnt_q);
  // Evaluated the cycle after the pop, when pop_cnt and stk_empty already reflect it.
  assign pend_last = ((pop_cnt_q == cmd_cnt_q) && (cmd_cnt_q != '0)) || stk_st.empty;

  assign cmd_ready = (state_q == IDLE);
  assign stk_pop   = (state_q == POP) && !stk_st.empty && !stk_st.push &&
                     (occupancy < 3'd3) && limit_ok;
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = POP;
      POP:     if ((pend_valid_q && pend_last) || (!pend_valid_q && stk_st.empty)) state_d = FLUSH;
      FLUSH:   if ((obuf_count == 2'd0) && !pend_valid_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_cnt_q    <= '0;
      pop_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      done_count_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= stk_pop;
      if (cmd_valid && cmd_ready) begin
        cmd_cnt_q <= cmd_count;
        pop_cnt_q <= '0;
      end else if (stk_pop) begin
        pop_cnt_q <= pop_cnt_q + CNT_ONE;
      end
      if ((state_q == FLUSH) && (state_d == DONE)) begin
        done_count_q <= pop_cnt_q;
        underflow_q  <= (cmd_cnt_q != '0) && (pop_cnt_q < cmd_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stk_pop) begin
      pend_data_q <= stk_data;
    end
  end

  stack_drain_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (pend_valid_q),
    .wr_data_i  ({pend_last, pend_data_q}),
    .rd_ready_i (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  (obuf_rd_data),
    .count_o    (obuf_count)
  );

  assign out_data   = obuf_rd_data[WIDTH-1:0];
  assign out_last   = obuf_rd_data[WIDTH];
  assign done_count = done_count_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_stack_drain.sv
// Directed bench for stack_drain with a small behavioural LIFO attached.
module tb_stack_drain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [WIDTH-1:0] VA = 32'hA0A0_0001;
  localparam logic [WIDTH-1:0] VB = 32'hB0B0_0002;
  localparam logic [WIDTH-1:0] VC = 32'hC0C0_0003;
  localparam logic [WIDTH-1:0] VD = 32'hD0D0_0004;
  localparam logic [WIDTH-1:0] VX = 32'h5A5A_00EE;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] stk_data;
  logic             stk_empty;
  logic             stk_push;
  logic [WIDTH-1:0] push_data;
  logic             stk_pop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             done;
  logic [CNT_W-1:0] done_count;
  logic             underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] smem [DEPTH];
  int sp = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  logic [WIDTH:0] beats [$];
  int beat_cyc [$];
  int pop_cyc [$];

  always #5 clk = ~clk;

  stack_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .stk_data(stk_data), .stk_empty(stk_empty),
    .stk_push(stk_push), .stk_pop(stk_pop), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .done_count(done_count), .underflow(underflow)
  );

  assign stk_empty = (sp == 0);
  assign stk_data  = (sp == 0) ? '0 : smem[sp-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_push && sp < DEPTH) begin
      smem[sp] <= push_data;
      sp <= sp + 1;
    end else if (stk_pop && sp != 0) begin
      sp <= sp - 1;
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beats.push_back({out_last, out_data});
      beat_cyc.push_back(cyc);
    end
    if (stk_pop) pop_cyc.push_back(cyc);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [WIDTH-1:0] v);
    stk_push = 1'b1;
    push_data = v;
    tick();
    stk_push = 1'b0;
  endtask

  task automatic start(input logic [CNT_W-1:0] n);
    cmd_valid = 1'b1;
    cmd_count = n;
    #1;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
    tick();
    tick();
    check(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  int bb;
  int pb;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
    stk_push = 1'b0; push_data = '0; out_ready = 1'b1;
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_outs", {56'd0, out_valid, out_last, stk_pop, done, underflow, done_count}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Full drain until empty, streaming at one beat per cycle.
    push_val(VA); push_val(VB); push_val(VC); push_val(VD);
    bb = beats.size(); pb = pop_cyc.size();
    start('0);
    wait_done("s1_done");
    check("s1_nbeats", 64'(beats.size() - bb), 64'd4);
    check("s1_b0", 64'(beats[bb+0]), {31'd0, 1'b0, VD});
    check("s1_b1", 64'(beats[bb+1]), {31'd0, 1'b0, VC});
    check("s1_b2", 64'(beats[bb+2]), {31'd0, 1'b0, VB});
    check("s1_b3", 64'(beats[bb+3]), {31'd0, 1'b1, VA});
    check("s1_pop_lat", 64'(pop_cyc[pb] - acc_cyc), 64'd1);
    check("s1_out_lat", 64'(beat_cyc[bb] - pop_cyc[pb]), 64'd2);
    check("s1_back2back", 64'(beat_cyc[bb+3] - beat_cyc[bb]), 64'd3);
    check("s1_done_count", 64'(done_count), 64'd4);
    check("s1_underflow", 64'(underflow), 64'd0);
    check("s1_idle", {62'd0, cmd_ready, out_valid}, 64'd2);

    // Counted drain leaves the bottom entry behind.
    push_val(VA); push_val(VB); push_val(VC);
    bb = beats.size();
    start(3'd2);
    wait_done("s2_done");
    check("s2_nbeats", 64'(beats.size() - bb), 64'd2);
    check("s2_b0", 64'(beats[bb+0]), {31'd0, 1'b0, VC});
    check("s2_b1", 64'(beats[bb+1]), {31'd0, 1'b1, VB});
    check("s2_stack_sp", 64'(sp), 64'd1);
    check("s2_stack_top", 64'(stk_data), 64'(VA));
    check("s2_done_count", 64'(done_count), 64'd2);
    check("s2_underflow", 64'(underflow), 64'd0);

    bb = beats.size();
    start(3'd1);
    wait_done("s2b_done");
    check("s2b_beat", 64'(beats[bb]), {31'd0, 1'b1, VA});
    check("s2b_done_count", 64'(done_count), 64'd1);

    // Empty stack with a count: no beats, underflow.
    bb = beats.size();
    start(3'd3);
    wait_done("s3_done");
    check("s3_nbeats", 64'(beats.size() - bb), 64'd0);
    check("s3_done_lat", 64'(done_cyc - acc_cyc), 64'd3);
    check("s3_done_count", 64'(done_count), 64'd0);
    check("s3_underflow", 64'(underflow), 64'd1);

    // Count larger than depth ends on empty.
    push_val(VA); push_val(VB); push_val(VC); push_val(VD);
    bb = beats.size();
    start(3'd5);
    wait_done("s4_done");
    check("s4_nbeats", 64'(beats.size() - bb), 64'd4);
    check("s4_last", 64'(beats[bb+3]), {31'd0, 1'b1, VA});
    check("s4_done_count", 64'(done_count), 64'd4);
    check("s4_underflow", 64'(underflow), 64'd1);

    // Backpressure: buffer fills, pops stall, head stays put.
    push_val(VA); push_val(VB); push_val(VC); push_val(VD);
    out_ready = 1'b0;
    bb = beats.size(); pb = pop_cyc.size();
    start('0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check("s5_hold_valid", 64'(out_valid), 64'd1);
        check("s5_hold_data", {31'd0, out_last, out_data}, {31'd0, 1'b0, VD});
      end
      tick();
    end
    check("s5_stall_pops", 64'(pop_cyc.size() - pb), 64'd3);
    out_ready = 1'b1;
    wait_done("s5_done");
    check("s5_nbeats", 64'(beats.size() - bb), 64'd4);
    check("s5_b1", 64'(beats[bb+1]), {31'd0, 1'b0, VC});
    check("s5_b3", 64'(beats[bb+3]), {31'd0, 1'b1, VA});
    check("s5_done_count", 64'(done_count), 64'd4);

    // Push colliding with the first POP cycle.
    push_val(VA); push_val(VB); push_val(VC);
    bb = beats.size();
    start('0);
    stk_push = 1'b1; push_data = VX;
    @(negedge clk);
    check("s6_no_pop_on_push", 64'(stk_pop), 64'd0);
    tick();
    stk_push = 1'b0;
    wait_done("s6_done");
    check("s6_nbeats", 64'(beats.size() - bb), 64'd4);
    check("s6_b0", 64'(beats[bb+0]), {31'd0, 1'b0, VX});
    check("s6_b3", 64'(beats[bb+3]), {31'd0, 1'b1, VA});
    check("s6_done_count", 64'(done_count), 64'd4);

    // Reset in the middle of a drain.
    push_val(VA); push_val(VB); push_val(VC); push_val(VD);
    bb = beats.size();
    pb = done_cnt;
    start('0);
    tick(); tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    check("s7_beats_before", 64'(beats.size() - bb), 64'd2);
    check("s7_rst_outs", {56'd0, out_valid, out_last, stk_pop, done, underflow, done_count}, 64'd0);
    check("s7_rst_data", 64'(out_data), 64'd0);
    check("s7_rst_ready", 64'(cmd_ready), 64'd1);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("s7_no_done", 64'(done_cnt - pb), 64'd0);
    check("s7_no_beats", 64'(beats.size() - bb), 64'd2);
    check("s7_idle", {62'd0, cmd_ready, out_valid}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_drain.md
STACK_DRAIN -- requirements
Module: stack_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits, equal to the attached stack's WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4, stack depth (power of two), equal to the attached stack's DEPTH.
REQ-003 SHALL have derived localparam CNT_W = $clog2(DEPTH)+1, the count width.
REQ-004 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1 / cmd_ready out 1  drain-command handshake.
REQ-007 SHALL have port cmd_count  in  CNT_W  entries to pop; 0 means drain until empty.
REQ-008 SHALL have ports stk_data in WIDTH / stk_empty in 1 / stk_push in 1  stack top-of-stack data, empty flag and push observed from the stack's pusher.
REQ-009 SHALL have port stk_pop  out  1  pop strobe to the stack.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1 / out_data out WIDTH / out_last out 1  output stream.
REQ-011 SHALL have ports done out 1 (one-cycle pulse) / done_count out CNT_W / underflow out 1  completion status.

Function
REQ-012 SHALL implement FSM states IDLE, POP, FLUSH and DONE.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; a cmd_valid&cmd_ready cycle latches cmd_count, clears pop_cnt and moves the FSM to POP.
REQ-014 SHALL assert stk_pop in POP only when all hold: !stk_empty, !stk_push, (obuf_count+pend_valid)<3, and limit not reached (cmd_count==0 or pop_cnt<cmd_count).
REQ-015 SHALL, on each stk_pop cycle, capture stk_data into the pend register (pend_valid=1) and increment pop_cnt.
REQ-016 SHALL, on the cycle after a pop, move pend into the output buffer with last=(pop_cnt==cmd_count && cmd_count!=0) || stk_empty.
REQ-017 SHALL give pop-to-out_valid latency of exactly 2 cycles when the output buffer is empty.
REQ-018 SHALL sustain 1 entry/cycle with out_ready held high.
REQ-019 SHALL keep out_data/out_last stable while out_valid&&!out_ready; a beat transfers on out_valid&&out_ready.
REQ-020 SHALL move POP->FLUSH when the last-tagged entry enters the buffer.
REQ-021 SHALL move POP->FLUSH with no output beats if stk_empty and !pend_valid on the first POP cycle.
REQ-022 SHALL move FLUSH->DONE when the output buffer and pend are both empty.
REQ-023 SHALL, in DONE for one cycle, pulse done=1 with done_count=pop_cnt, underflow=(cmd_count!=0 && pop_cnt<cmd_count), then return to IDLE.
REQ-024 SHALL hold done_count and underflow until the next done.
REQ-025 SHALL suppress stk_pop in any cycle with stk_push=1; the pop is retried on the next eligible cycle.
REQ-026 SHALL end the drain on empty when cmd_count>DEPTH, setting underflow=1.
REQ-027 SHALL ignore out_ready and cmd_valid outside their handshake states.

Reset
REQ-028 SHALL, while reset_n=0, set FSM=IDLE, pop_cnt=0, pend_valid=0, output buffer empty, stk_pop=0, out_valid=0, out_last=0, out_data=0, done=0, done_count=0, underflow=0; cmd_ready=1.
REQ-029 SHALL, on reset mid-drain, discard pending and buffered entries and produce no done pulse.

Structure
REQ-030 SHALL declare drain_state_t (IDLE/POP/FLUSH/DONE) in shared package stack_pkg, alongside the stack status typedef.
REQ-031 SHALL implement the output buffer as sub-module stack_drain_obuf: 3-entry FIFO of {last, data} with count output.
REQ-032 SHALL connect stk_pop directly to the stack pop input with no extra register.

Verification (WIDTH=32, DEPTH=4, with the stack instantiated)
REQ-033 Push A,B,C,D; cmd_count=0; out_ready=1 -> beats D,C,B,A on consecutive cycles, last on A, done_count=4, underflow=0.
REQ-034 Push A,B,C; cmd_count=2 -> beats C,B, last on B; stack retains A; done_count=2, underflow=0.
REQ-035 Empty stack; cmd_count=3 -> no beats, done 1 cycle after FLUSH, done_count=0, underflow=1.
REQ-036 Push 4 entries; out_ready low for 5 cycles -> at most 3 buffered plus 1 pend, stk_pop stalls, data stable, no loss after release.
REQ-037 stk_push asserted during POP -> no stk_pop that cycle; the pushed value becomes the next beat.
REQ-038 Reset asserted mid-drain after 2 beats -> all outputs return to reset values, no done, cmd_ready=1 after release.
